mod_demod_core: RTL

- Parametrised multi-mode digital modulator with a symbol-synchronous demodulator. Successor to the fixed 2-bit-select modulator/demodulator top.
- Accepts a stream of data bits through a FIFO and emits one OUT_W-bit carrier sample per cycle, in ASK, FSK, BPSK or PWM mode.
- Demodulates an OUT_W-bit sample stream back to bits. The stream is normally `mod_out` looped back externally.
- Sits directly under the TT top, which maps `sel`/`mod_out`/`demod_bit` onto the ui/uo pins.

---
 rtl/mod_demod_pkg.sv | 22 ++
 rtl/bit_fifo.sv | 47 ++++
 rtl/mod_demod_core.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_demod_pkg.sv
// Shared types and helpers for the multi-mode modulator/demodulator.
package mod_demod_pkg;

  // Widest phase slice tri_map() can fold; OUT_W must stay below this.
  localparam int unsigned TRI_MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_ASK  = 2'b00,
    MODE_FSK  = 2'b01,
    MODE_BPSK = 2'b10,
    MODE_PWM  = 2'b11
  } mode_e;

  // Folds a (w+1)-bit phase slice into a w-bit unsigned triangle.
  function automatic logic [TRI_MAX_W-1:0] tri_map(input logic [TRI_MAX_W-1:0] p,
                                                   input int unsigned w);
    logic [TRI_MAX_W-1:0] mask;
    mask = TRI_MAX_W'((32'd1 << w) - 32'd1);
    return p[w[3:0]] ? (~p & mask) : (p & mask);
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// Single-bit FIFO with valid/ready push and a pop strobe; DEPTH must be a power of 2 (>= 2).
module bit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_bit,
  output logic push_ready,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign head       = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_bit;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_demod_core.sv
// ASK/FSK/BPSK/PWM modulator with a symbol-synchronous demodulator sharing one symbol timer.
// Optional bit-error counter enabled by defining MOD_DEMOD_ERRCNT_EN.
module mod_demod_core
  import mod_demod_pkg::*;
#(
  parameter int unsigned OUT_W   = 7,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned SYM_CYC = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned F0_INC  = 16,
  parameter int unsigned F1_INC  = 64,
  parameter int unsigned FSK_THR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [OUT_W-1:0] mod_out,
  input  logic [OUT_W-1:0] demod_in,
  output logic             demod_bit,
  output logic             demod_valid,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CW = $clog2(SYM_CYC);
  localparam int unsigned NW = $clog2(SYM_CYC + 1);
  localparam logic [CW-1:0] LAST  = CW'(SYM_CYC - 1);
  localparam logic [CW-1:0] DUTY1 = CW'(3 * SYM_CYC / 4);
  localparam logic [CW-1:0] DUTY0 = CW'(SYM_CYC / 4);
  localparam logic [NW-1:0] HALF  = NW'(SYM_CYC / 2);
  localparam logic [NW-1:0] THR   = NW'(FSK_THR);

  // Transmit side
  logic [CW-1:0]      scnt;
  logic               boundary;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] cur_phase;
  logic [PHASE_W-1:0] inc;
  mode_e              mode_q;
  mode_e              cur_mode;
  logic               data_q;
  logic               bit_q;
  logic               cur_data;
  logic               cur_bit;
  logic [OUT_W:0]     p;
  logic [OUT_W-1:0]   tri_val;
  logic [OUT_W-1:0]   sample;
  logic               fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_ready;

  // Demodulator side, aligned with the sample currently on mod_out
  logic [CW-1:0]      d_scnt;
  mode_e              d_mode;
  logic               d_data;
  logic               d_ref;
  logic               win_start;
  logic               win_last;
  logic               m;
  logic [NW-1:0]      cnt;
  logic [NW-1:0]      base_cnt;
  logic [NW-1:0]      cnt_next;
  logic [OUT_W-1:0]   peak;
  logic [OUT_W-1:0]   base_peak;
  logic [OUT_W-1:0]   peak_next;
  logic               prev_m;
  logic               base_prev;
  logic               hit;
  logic               decision;

  assign boundary = (scnt == '0);

  bit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(in_valid),
    .push_bit  (in_bit),
    .push_ready(fifo_ready),
    .pop       (boundary),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign in_ready = fifo_ready;

  // At a boundary the new symbol's attributes come straight from the FIFO and sel.
  always_comb begin
    cur_data  = boundary ? !fifo_empty : data_q;
    cur_mode  = boundary ? mode_e'(sel) : mode_q;
    cur_bit   = boundary ? (fifo_head & !fifo_empty) : bit_q;
    cur_phase = boundary ? '0 : phase;
    inc       = (cur_mode == MODE_FSK && cur_bit) ? PHASE_W'(F1_INC) : PHASE_W'(F0_INC);
  end

  assign p       = cur_phase[PHASE_W-1 -: OUT_W+1];
  assign tri_val = OUT_W'(tri_map(TRI_MAX_W'(p), OUT_W));

  always_comb begin
    sample = '0;
    if (cur_data) begin
      unique case (cur_mode)
        MODE_ASK:  sample = cur_bit ? tri_val : (tri_val >> 2);
        MODE_FSK:  sample = tri_val;
        MODE_BPSK: sample = cur_bit ? tri_val : ~tri_val;
        MODE_PWM:  sample = (scnt < (cur_bit ? DUTY1 : DUTY0)) ? '1 : '0;
        default:   sample = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt    <= '0;
      phase   <= '0;
      mode_q  <= MODE_ASK;
      data_q  <= 1'b0;
      bit_q   <= 1'b0;
      mod_out <= '0;
      d_scnt  <= '0;
      d_mode  <= MODE_ASK;
      d_data  <= 1'b0;
      d_ref   <= 1'b0;
    end else begin
      scnt    <= (scnt == LAST) ? '0 : scnt + 1'b1;
      phase   <= cur_phase + inc;
      mode_q  <= cur_mode;
      data_q  <= cur_data;
      bit_q   <= cur_bit;
      mod_out <= sample;
      d_scnt  <= scnt;
      d_mode  <= cur_mode;
      d_data  <= cur_data;
      d_ref   <= tri_val[OUT_W-1];
    end
  end

  assign busy      = d_data;
  assign win_start = (d_scnt == '0);
  assign win_last  = (d_scnt == LAST);
  assign m         = demod_in[OUT_W-1];

  always_comb begin
    base_cnt  = win_start ? '0 : cnt;
    base_peak = win_start ? '0 : peak;
    base_prev = win_start ? 1'b0 : prev_m;
    case (d_mode)
      MODE_FSK:  hit = m & ~base_prev;
      MODE_BPSK: hit = (m == d_ref);
      default:   hit = m;
    endcase
    cnt_next  = base_cnt + NW'(hit);
    peak_next = (demod_in > base_peak) ? demod_in : base_peak;
    case (d_mode)
      MODE_ASK: decision = peak_next[OUT_W-1];
      MODE_FSK: decision = (cnt_next >= THR);
      default:  decision = (cnt_next > HALF);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      peak        <= '0;
      prev_m      <= 1'b0;
      demod_valid <= 1'b0;
      demod_bit   <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      peak        <= peak_next;
      prev_m      <= m;
      demod_valid <= d_data && win_last;
      if (d_data && win_last) begin
        demod_bit <= decision;
      end
    end
  end

`ifdef MOD_DEMOD_ERRCNT_EN
  logic       d_bit;
  logic [7:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_bit <= 1'b0;
      err_q <= '0;
    end else begin
      d_bit <= cur_bit;
      if (d_data && win_last && (decision != d_bit) && (err_q != 8'hff)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
